// File: rtl/aurora_tx_frame_gen.sv
// aurora_tx_frame_gen: numbered fixed-length frame source for the Aurora TX AXI-stream port.
// Each frame is one header word {HEADER_TAG, seq} and FRAME_LEN-1 payload words, followed
// by GAP_CYCLES idle cycles. Generation runs only while the Aurora channel is up.
// Build macro TX_FRAME_GEN_LFSR_EN: payload words come from a 32-bit Fibonacci LFSR
// (x^32+x^22+x^2+x+1) that advances on accepted payload beats only; when undefined the
// payload is the {seq, beat} counter pattern and no LFSR logic exists.
module aurora_tx_frame_gen #(
    parameter int unsigned FRAME_LEN  = 16,
    parameter int unsigned GAP_CYCLES = 4,
    parameter logic [15:0] HEADER_TAG = 16'hCAFE
) (
    input  logic        USER_CLK,
    input  logic        RESET,
    input  logic        CHANNEL_UP,
    input  logic        GEN_EN,
    output logic [0:31] TX_TDATA_O,
    output logic        TX_TVALID_O,
    output logic [0:3]  TX_TKEEP_O,
    output logic        TX_TLAST_O,
    input  logic        TX_TREADY_IN,
    output logic [31:0] FRAME_CNT_O,
    output logic [15:0] ABORT_CNT_O,
    output logic        BUSY_O
);

    localparam int unsigned BEAT_W    = 16;
    localparam int unsigned GAP_W     = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(FRAME_LEN - 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_HEADER  = 2'd1;
    localparam logic [1:0] ST_PAYLOAD = 2'd2;
    localparam logic [1:0] ST_GAP     = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [31:0]       tdata_q, tdata_d;
    logic              tvalid_q, tvalid_d;
    logic [3:0]        tkeep_q, tkeep_d;
    logic              tlast_q, tlast_d;
    logic              busy_q, busy_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [15:0]       seq_q, seq_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [31:0]       frame_cnt_q, frame_cnt_d;
    logic [15:0]       abort_cnt_q, abort_cnt_d;

    logic              hs;
    logic              abort;
    logic [BEAT_W-1:0] beat_nxt;
    logic [31:0]       payload;

`ifdef TX_FRAME_GEN_LFSR_EN
    logic [31:0] lfsr_q, lfsr_d, lfsr_adv;

    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        return {v[30:0], v[31] ^ v[21] ^ v[1] ^ v[0]};
    endfunction
`endif

    // Next-state, next-output and counter logic
    always_comb begin
        state_d     = state_q;
        tdata_d     = tdata_q;
        tvalid_d    = tvalid_q;
        tlast_d     = tlast_q;
        beat_d      = beat_q;
        seq_d       = seq_q;
        gap_d       = gap_q;
        frame_cnt_d = frame_cnt_q;
        abort_cnt_d = abort_cnt_q;
        abort       = 1'b0;
        hs          = tvalid_q & TX_TREADY_IN;
        beat_nxt    = (state_q == ST_HEADER) ? BEAT_W'(1) : beat_q + BEAT_W'(1);
`ifdef TX_FRAME_GEN_LFSR_EN
        // The word being presented next is always one step ahead of the committed state
        lfsr_adv    = (state_q == ST_PAYLOAD && hs) ? lfsr_step(lfsr_q) : lfsr_q;
        lfsr_d      = lfsr_adv;
        payload     = lfsr_step(lfsr_adv);
`else
        payload     = {seq_q, beat_nxt};
`endif

        case (state_q)
            ST_IDLE: begin
                if (CHANNEL_UP && GEN_EN) begin
                    state_d  = ST_HEADER;
                    tvalid_d = 1'b1;
                    tdata_d  = {HEADER_TAG, seq_q};
                    tlast_d  = 1'b0;
                end
            end
            ST_HEADER: begin
                if (!CHANNEL_UP) begin
                    abort = 1'b1;
                end else if (hs) begin
                    state_d = ST_PAYLOAD;
                    beat_d  = beat_nxt;
                    tdata_d = payload;
                    tlast_d = (beat_nxt == LAST_BEAT);
                end
            end
            ST_PAYLOAD: begin
                if (hs && tlast_q) begin
                    // Completion wins over a simultaneous channel drop
                    seq_d       = seq_q + 16'd1;
                    frame_cnt_d = frame_cnt_q + 32'd1;
                    beat_d      = '0;
                    tlast_d     = 1'b0;
                    if (GAP_CYCLES != 0) begin
                        state_d  = ST_GAP;
                        gap_d    = '0;
                        tvalid_d = 1'b0;
                    end else if (CHANNEL_UP && GEN_EN) begin
                        state_d  = ST_HEADER;
                        tvalid_d = 1'b1;
                        tdata_d  = {HEADER_TAG, seq_d};
                    end else begin
                        state_d  = ST_IDLE;
                        tvalid_d = 1'b0;
                    end
                end else if (!CHANNEL_UP) begin
                    abort = 1'b1;
                end else if (hs) begin
                    beat_d  = beat_nxt;
                    tdata_d = payload;
                    tlast_d = (beat_nxt == LAST_BEAT);
                end
            end
            ST_GAP: begin
                if (!CHANNEL_UP) begin
                    state_d = ST_IDLE;
                    gap_d   = '0;
                end else if (32'(gap_q) + 32'd1 >= GAP_CYCLES) begin
                    gap_d = '0;
                    if (GEN_EN) begin
                        state_d  = ST_HEADER;
                        tvalid_d = 1'b1;
                        tdata_d  = {HEADER_TAG, seq_q};
                        tlast_d  = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Channel loss mid-frame: drop valid, keep seq so the frame is retried
        if (abort) begin
            state_d  = ST_IDLE;
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            beat_d   = '0;
            if (abort_cnt_q != 16'hFFFF) begin
                abort_cnt_d = abort_cnt_q + 16'd1;
            end
        end

        tkeep_d = tvalid_d ? 4'hF : 4'h0;
        busy_d  = (state_d == ST_HEADER) || (state_d == ST_PAYLOAD);
    end

    // State and output registers
    always_ff @(posedge USER_CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            tdata_q     <= '0;
            tvalid_q    <= 1'b0;
            tkeep_q     <= '0;
            tlast_q     <= 1'b0;
            busy_q      <= 1'b0;
            beat_q      <= '0;
            seq_q       <= '0;
            gap_q       <= '0;
            frame_cnt_q <= '0;
            abort_cnt_q <= '0;
`ifdef TX_FRAME_GEN_LFSR_EN
            lfsr_q      <= 32'hFFFF_FFFF;
`endif
        end else begin
            state_q     <= state_d;
            tdata_q     <= tdata_d;
            tvalid_q    <= tvalid_d;
            tkeep_q     <= tkeep_d;
            tlast_q     <= tlast_d;
            busy_q      <= busy_d;
            beat_q      <= beat_d;
            seq_q       <= seq_d;
            gap_q       <= gap_d;
            frame_cnt_q <= frame_cnt_d;
            abort_cnt_q <= abort_cnt_d;
`ifdef TX_FRAME_GEN_LFSR_EN
            lfsr_q      <= lfsr_d;
`endif
        end
    end

    assign TX_TDATA_O  = tdata_q;
    assign TX_TVALID_O = tvalid_q;
    assign TX_TKEEP_O  = tkeep_q;
    assign TX_TLAST_O  = tlast_q;
    assign FRAME_CNT_O = frame_cnt_q;
    assign ABORT_CNT_O = abort_cnt_q;
    assign BUSY_O      = busy_q;

endmodule

// File: tb/tb_aurora_tx_frame_gen.sv
// Bench for aurora_tx_frame_gen: instance A (4-word frames, 2-cycle gap) and
// instance B (16-word frames, no gap). Expected beats are queued when a scenario
// starts and popped by a per-instance monitor on every accepted beat.
`timescale 1ns/1ps
module tb_aurora_tx_frame_gen;

    localparam int unsigned FL_A  = 4;
    localparam int unsigned GAP_A = 2;
    localparam int unsigned FL_B  = 16;
    localparam int unsigned GAP_B = 0;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        a_chan, a_en, a_ready, a_valid, a_last, a_busy;
    logic [0:31] a_data;
    logic [0:3]  a_keep;
    logic [31:0] a_fcnt;
    logic [15:0] a_acnt;

    logic        b_chan, b_en, b_ready, b_valid, b_last, b_busy;
    logic [0:31] b_data;
    logic [0:3]  b_keep;
    logic [31:0] b_fcnt;
    logic [15:0] b_acnt;

    int n_cmp = 0;
    int n_bad = 0;

    logic [32:0] sb_a[$];
    logic [32:0] sb_b[$];
    logic [31:0] lfsr_a, lfsr_b;
    logic        a_stall, b_stall;
    logic [32:0] a_held, b_held, a_exp, b_exp;

    aurora_tx_frame_gen #(.FRAME_LEN(FL_A), .GAP_CYCLES(GAP_A), .HEADER_TAG(16'hCAFE)) u_dut_a (
        .USER_CLK(clk), .RESET(rst), .CHANNEL_UP(a_chan), .GEN_EN(a_en),
        .TX_TDATA_O(a_data), .TX_TVALID_O(a_valid), .TX_TKEEP_O(a_keep), .TX_TLAST_O(a_last),
        .TX_TREADY_IN(a_ready), .FRAME_CNT_O(a_fcnt), .ABORT_CNT_O(a_acnt), .BUSY_O(a_busy)
    );

    aurora_tx_frame_gen #(.FRAME_LEN(FL_B), .GAP_CYCLES(GAP_B), .HEADER_TAG(16'hCAFE)) u_dut_b (
        .USER_CLK(clk), .RESET(rst), .CHANNEL_UP(b_chan), .GEN_EN(b_en),
        .TX_TDATA_O(b_data), .TX_TVALID_O(b_valid), .TX_TKEEP_O(b_keep), .TX_TLAST_O(b_last),
        .TX_TREADY_IN(b_ready), .FRAME_CNT_O(b_fcnt), .ABORT_CNT_O(b_acnt), .BUSY_O(b_busy)
    );

`ifdef TX_FRAME_GEN_LFSR_EN
    function automatic logic [31:0] lfsr_next(input logic [31:0] v);
        return {v[30:0], v[31] ^ v[21] ^ v[1] ^ v[0]};
    endfunction
`endif

    // Queue the first nbeats words of frame s as {tlast, tdata}
    task automatic push_frame(input bit inst_b, input logic [15:0] s, input int nbeats, input int fl);
        logic [31:0] w;
        for (int i = 0; i < nbeats; i++) begin
            if (i == 0) begin
                w = {16'hCAFE, s};
            end else begin
`ifdef TX_FRAME_GEN_LFSR_EN
                if (inst_b) begin lfsr_b = lfsr_next(lfsr_b); w = lfsr_b; end
                else begin lfsr_a = lfsr_next(lfsr_a); w = lfsr_a; end
`else
                w = {s, 16'(i)};
`endif
            end
            if (inst_b) sb_b.push_back({(i == fl - 1), w});
            else        sb_a.push_back({(i == fl - 1), w});
        end
    endtask

    // Instance A monitor: hold-stable on stalls, keep, scoreboard pop on handshake
    always @(negedge clk) begin
        if (rst) begin
            a_stall = 1'b0;
        end else begin
            if (a_valid && a_stall) begin
                n_cmp++;
                if ({a_last, a_data} !== a_held) begin
                    n_bad++;
                    $display("FAIL a_hold: got %h required %h", {a_last, a_data}, a_held);
                end
            end
            if (!a_valid) begin
                n_cmp++;
                if (a_keep !== 4'h0) begin
                    n_bad++;
                    $display("FAIL a_keep_idle: got %h required 0", a_keep);
                end
            end
            if (a_valid && a_ready) begin
                n_cmp++;
                if (sb_a.size() == 0) begin
                    n_bad++;
                    $display("FAIL a_beat: unexpected beat %h last %b", a_data, a_last);
                end else begin
                    a_exp = sb_a.pop_front();
                    if ({a_last, a_data, a_keep} !== {a_exp, 4'hF}) begin
                        n_bad++;
                        $display("FAIL a_beat: got last=%b data=%h keep=%h required last=%b data=%h keep=f",
                                 a_last, a_data, a_keep, a_exp[32], a_exp[31:0]);
                    end
                end
            end
            a_stall = a_valid && !a_ready;
            a_held  = {a_last, a_data};
        end
    end

    // Instance B monitor
    always @(negedge clk) begin
        if (rst) begin
            b_stall = 1'b0;
        end else begin
            if (b_valid && b_stall) begin
                n_cmp++;
                if ({b_last, b_data} !== b_held) begin
                    n_bad++;
                    $display("FAIL b_hold: got %h required %h", {b_last, b_data}, b_held);
                end
            end
            if (!b_valid) begin
                n_cmp++;
                if (b_keep !== 4'h0) begin
                    n_bad++;
                    $display("FAIL b_keep_idle: got %h required 0", b_keep);
                end
            end
            if (b_valid && b_ready) begin
                n_cmp++;
                if (sb_b.size() == 0) begin
                    n_bad++;
                    $display("FAIL b_beat: unexpected beat %h last %b", b_data, b_last);
                end else begin
                    b_exp = sb_b.pop_front();
                    if ({b_last, b_data, b_keep} !== {b_exp, 4'hF}) begin
                        n_bad++;
                        $display("FAIL b_beat: got last=%b data=%h keep=%h required last=%b data=%h keep=f",
                                 b_last, b_data, b_keep, b_exp[32], b_exp[31:0]);
                    end
                end
            end
            b_stall = b_valid && !b_ready;
            b_held  = {b_last, b_data};
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        a_chan = 1'b0; a_en = 1'b0; a_ready = 1'b0;
        b_chan = 1'b0; b_en = 1'b0; b_ready = 1'b0;
        sb_a.delete(); sb_b.delete();
        lfsr_a = 32'hFFFF_FFFF; lfsr_b = 32'hFFFF_FFFF;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_cmp++;
        if ({a_valid, a_data, a_keep, a_last, a_fcnt, a_acnt, a_busy} !== '0) begin
            n_bad++;
            $display("FAIL reset_a: got %h required 0", {a_valid, a_data, a_keep, a_last, a_fcnt, a_acnt, a_busy});
        end
        n_cmp++;
        if ({b_valid, b_data, b_keep, b_last, b_fcnt, b_acnt, b_busy} !== '0) begin
            n_bad++;
            $display("FAIL reset_b: got %h required 0", {b_valid, b_data, b_keep, b_last, b_fcnt, b_acnt, b_busy});
        end
        a_chan = 1'b1; a_en = 1'b0;
        repeat (4) @(negedge clk);
        n_cmp++;
        if ({a_valid, a_busy} !== 2'b00) begin
            n_bad++;
            $display("FAIL idle_no_en: got valid/busy %b required 00", {a_valid, a_busy});
        end
        a_chan = 1'b0; a_en = 1'b1;
        repeat (4) @(negedge clk);
        n_cmp++;
        if ({a_valid, a_busy} !== 2'b00) begin
            n_bad++;
            $display("FAIL idle_no_chan: got valid/busy %b required 00", {a_valid, a_busy});
        end
        a_en = 1'b0;
    endtask

    task automatic test_basic();
        int n = 0;
        int idle = 0;
        push_frame(0, 16'd0, FL_A, FL_A);
        push_frame(0, 16'd1, FL_A, FL_A);
        @(posedge clk); #1;
        a_chan = 1'b1; a_en = 1'b1; a_ready = 1'b1;
        do begin @(negedge clk); n++; end while (!(a_valid && a_ready && a_last) && n < 50);
        n_cmp++;
        if (n >= 50) begin n_bad++; $display("FAIL basic_tlast: timeout after %0d cycles", n); end
        @(posedge clk); #1;
        n_cmp++;
        if (a_fcnt !== 32'd1) begin n_bad++; $display("FAIL basic_fcnt1: got %0d required 1", a_fcnt); end
        @(negedge clk);
        while (!a_valid && idle < 20) begin idle++; @(negedge clk); end
        n_cmp++;
        if (idle !== int'(GAP_A)) begin n_bad++; $display("FAIL basic_gap: got %0d idle cycles required %0d", idle, GAP_A); end
        n_cmp++;
        if (a_data !== 32'hCAFE_0001) begin n_bad++; $display("FAIL basic_hdr2: got %h required cafe0001", a_data); end
        a_en = 1'b0;
        n = 0;
        while (a_fcnt != 32'd2 && n < 50) begin @(negedge clk); n++; end
        repeat (6) @(negedge clk);
        n_cmp++;
        if ({a_valid, a_busy, a_fcnt} !== {2'b00, 32'd2} || sb_a.size() != 0) begin
            n_bad++;
            $display("FAIL basic_end: got valid=%b busy=%b fcnt=%0d pending=%0d required 0 0 2 0",
                     a_valid, a_busy, a_fcnt, sb_a.size());
        end
    endtask

    task automatic test_stall();
        int n = 0;
        bit done = 1'b0;
        push_frame(0, 16'd2, FL_A, FL_A);
        push_frame(0, 16'd3, FL_A, FL_A);
        push_frame(0, 16'd4, FL_A, FL_A);
        a_en = 1'b1;
        while (n < 2000 && !done) begin
            @(posedge clk); #1;
            a_ready = 1'($urandom_range(0, 1));
            if (a_busy && a_fcnt == 32'd4) a_en = 1'b0;
            if (a_fcnt == 32'd5) done = 1'b1;
            n++;
        end
        n_cmp++;
        if (!done) begin n_bad++; $display("FAIL stall_done: timeout, fcnt=%0d required 5", a_fcnt); end
        a_ready = 1'b1;
        repeat (6) @(negedge clk);
        n_cmp++;
        if ({a_valid, a_busy, a_fcnt} !== {2'b00, 32'd5} || sb_a.size() != 0) begin
            n_bad++;
            $display("FAIL stall_end: got valid=%b busy=%b fcnt=%0d pending=%0d required 0 0 5 0",
                     a_valid, a_busy, a_fcnt, sb_a.size());
        end
    endtask

    task automatic test_abort();
        int n = 0;
        logic [31:0] w;
        push_frame(0, 16'd5, 2, FL_A);
        a_ready = 1'b1; a_en = 1'b1;
        while (sb_a.size() != 0 && n < 50) begin @(posedge clk); n++; end
        n_cmp++;
        if (n >= 50) begin n_bad++; $display("FAIL abort_start: timeout"); end
        #1;
`ifdef TX_FRAME_GEN_LFSR_EN
        w = lfsr_next(lfsr_a);
`else
        w = {16'd5, 16'd2};
`endif
        n_cmp++;
        if ({a_valid, a_last, a_data} !== {2'b10, w}) begin
            n_bad++;
            $display("FAIL abort_beat2: got valid=%b last=%b data=%h required 1 0 %h", a_valid, a_last, a_data, w);
        end
        a_chan = 1'b0; a_ready = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if ({a_valid, a_busy, a_acnt, a_fcnt} !== {2'b00, 16'd1, 32'd5}) begin
            n_bad++;
            $display("FAIL abort_drop: got valid=%b busy=%b acnt=%0d fcnt=%0d required 0 0 1 5",
                     a_valid, a_busy, a_acnt, a_fcnt);
        end
        repeat (10) @(posedge clk); #1;
        n_cmp++;
        if ({a_valid, a_acnt} !== {1'b0, 16'd1}) begin
            n_bad++;
            $display("FAIL abort_down: got valid=%b acnt=%0d required 0 1", a_valid, a_acnt);
        end
        push_frame(0, 16'd5, FL_A, FL_A);
        a_chan = 1'b1; a_ready = 1'b1;
        n = 0;
        while (sb_a.size() != 0 && n < 50) begin @(posedge clk); n++; end
        n_cmp++;
        if (n >= 50) begin n_bad++; $display("FAIL abort_retry: timeout"); end
        #1;
        a_chan = 1'b0;
        a_en = 1'b0;
        repeat (4) @(posedge clk); #1;
        n_cmp++;
        if ({a_valid, a_busy, a_acnt, a_fcnt} !== {2'b00, 16'd1, 32'd6}) begin
            n_bad++;
            $display("FAIL abort_gapdrop: got valid=%b busy=%b acnt=%0d fcnt=%0d required 0 0 1 6",
                     a_valid, a_busy, a_acnt, a_fcnt);
        end
        a_chan = 1'b1;
    endtask

    task automatic test_gen_en_midframe();
        int n = 0;
        int vcnt = 0;
        push_frame(1, 16'd0, FL_B, FL_B);
        b_chan = 1'b1; b_ready = 1'b1; b_en = 1'b1;
        while (sb_b.size() > FL_B - 1 && n < 50) begin @(posedge clk); n++; end
        #1;
        b_en = 1'b0;
        n = 0;
        while (b_fcnt != 32'd1 && n < 100) begin @(posedge clk); #1; n++; end
        n_cmp++;
        if (n >= 100) begin n_bad++; $display("FAIL gen_en_complete: timeout, fcnt=%0d", b_fcnt); end
        repeat (20) begin @(negedge clk); if (b_valid) vcnt++; end
        n_cmp++;
        if (vcnt != 0 || b_busy !== 1'b0 || b_fcnt !== 32'd1 || sb_b.size() != 0) begin
            n_bad++;
            $display("FAIL gen_en_idle: got valid_cycles=%0d busy=%b fcnt=%0d pending=%0d required 0 0 1 0",
                     vcnt, b_busy, b_fcnt, sb_b.size());
        end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        int run = 0;
        bit started = 1'b0;
        push_frame(1, 16'd1, FL_B, FL_B);
        push_frame(1, 16'd2, FL_B, FL_B);
        push_frame(1, 16'd3, FL_B, FL_B);
        b_en = 1'b1;
        while (n < 300) begin
            @(negedge clk);
            n++;
            if (b_valid) begin started = 1'b1; run++; end
            else if (started) break;
            if (b_fcnt == 32'd3 && b_busy) b_en = 1'b0;
        end
        n_cmp++;
        if (run != 3 * int'(FL_B)) begin
            n_bad++;
            $display("FAIL b2b_run: got %0d consecutive valid cycles required %0d", run, 3 * FL_B);
        end
        n_cmp++;
        if (b_fcnt !== 32'd4 || sb_b.size() != 0) begin
            n_bad++;
            $display("FAIL b2b_end: got fcnt=%0d pending=%0d required 4 0", b_fcnt, sb_b.size());
        end
    endtask

    task automatic test_reset_mid_frame();
        int n = 0;
        a_chan = 1'b1; a_ready = 1'b1; a_en = 1'b1;
        b_chan = 1'b0; b_en = 1'b0;
        push_frame(0, 16'd6, FL_A, FL_A);
        while (!a_busy && n < 20) begin @(posedge clk); #1; n++; end
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({a_valid, a_keep, a_last, a_fcnt, a_acnt, a_busy, b_fcnt} !== '0) begin
            n_bad++;
            $display("FAIL reset_mid: got valid=%b keep=%h last=%b fcnt=%0d acnt=%0d busy=%b bfcnt=%0d required all 0",
                     a_valid, a_keep, a_last, a_fcnt, a_acnt, a_busy, b_fcnt);
        end
        sb_a.delete(); sb_b.delete();
        lfsr_a = 32'hFFFF_FFFF; lfsr_b = 32'hFFFF_FFFF;
        push_frame(0, 16'd0, FL_A, FL_A);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        n = 0;
        while (!a_busy && n < 20) begin @(posedge clk); #1; n++; end
        a_en = 1'b0;
        n = 0;
        while (a_fcnt != 32'd1 && n < 50) begin @(posedge clk); #1; n++; end
        repeat (6) @(negedge clk);
        n_cmp++;
        if ({a_valid, a_busy, a_fcnt} !== {2'b00, 32'd1} || sb_a.size() != 0) begin
            n_bad++;
            $display("FAIL reset_restart: got valid=%b busy=%b fcnt=%0d pending=%0d required 0 0 1 0",
                     a_valid, a_busy, a_fcnt, sb_a.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_abort();
        test_gen_en_midframe();
        test_back_to_back();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
